sensor_scan_mux: RTL
====================

# sensor_scan_mux

Parametrised, registered N-to-1 channel selector for the home-automation sensor datapath, generalising the fixed 2:1 and 4:1 selectors. It supports a manual mode (host-selected channel) and an autonomous round-robin scan mode with a programmable dwell time, per-channel enable masking, and a scan hold. It sits between the sensor input registers and the control/display logic. Each capture is presented with its channel index and a valid strobe.

## Interface
- CHANNELS, 4: number of input channels, must be ≥2.
- WIDTH, 8: bits per channel.
- DWELL, 16: clock cycles spent on each channel in scan mode, must be ≥1.
- SEL_W, $clog2(CHANNELS): derived localparam; width of channel indices.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- mode  in  1  0 = manual, 1 = scan.
- man_sel  in  SEL_W  channel selected in manual mode.
- hold  in  1  scan mode only; freezes the scan.
- chan_en  in  CHANNELS  per-channel enable for scan; bit i enables channel i.
- in_data  in  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- out_data  out  WIDTH  registered selected data.
- out_chan  out  SEL_W  channel index of out_data.
- out_valid  out  1  manual mode: level; scan mode: 1-cycle capture pulse.

## Operation
- **States.**
  - MANUAL: the reset state.
  - SCAN.
  - HALT: scan mode with chan_en == 0.
- **Internal registers.**
  - cur [SEL_W]: current scan channel.
  - cnt: dwell counter, range 0..DWELL-1.
- **Reset.** All outputs are 0; cur = 0; cnt = 0; state = MANUAL. Reset is asynchronous and takes effect mid-operation with no completion of the in-flight dwell.
- **MANUAL.**
  - Each edge with man_sel < CHANNELS: out_data = in_data[man_sel], out_chan = man_sel, out_valid = 1.
  - man_sel ≥ CHANNELS: out_data = 0, out_chan = 0, out_valid = 0.
  - chan_en and hold are ignored.
- **MANUAL → SCAN/HALT.** On the edge sampling mode = 1:
  - cnt = 0, cur = lowest enabled channel, out_valid = 0, out_data and out_chan hold.
  - If chan_en == 0, go to HALT instead of SCAN.
- **SCAN, hold = 1.** cnt, cur, out_data and out_chan hold; out_valid = 0.
- **SCAN, cnt < DWELL-1.** cnt increments; out_valid = 0.
- **SCAN, cnt == DWELL-1 (terminal).**
  - If chan_en[cur] = 1: out_data = in_data[cur], out_chan = cur, out_valid = 1 for one cycle.
  - If chan_en[cur] was dropped mid-dwell: no capture, out_valid = 0.
  - In both cases cnt = 0 and cur advances to the next enabled channel, searching cur+1, cur+2, … with wrap CHANNELS-1 → 0.
  - cur itself is the last candidate, so a single enabled channel re-selects itself.
- **SCAN → HALT.** If chan_en == 0 at the terminal edge, or at any edge, go to HALT with cnt = 0 and out_valid = 0.
- **HALT.**
  - Outputs hold; out_valid = 0.
  - On the first edge with chan_en ≠ 0: go to SCAN with cnt = 0 and cur = lowest enabled channel.
- **SCAN/HALT → MANUAL.** On the edge sampling mode = 0, go to MANUAL; that same edge performs the manual update.
- **Priority.** Reset > mode > chan_en == 0 > hold > dwell count.
- **Data path.**
  - No arithmetic on data; only selection.
  - cnt is $clog2(DWELL)+1 bits wide and never exceeds DWELL-1.

## Timing
- **Manual latency.** 1 cycle from a man_sel or in_data change to out_data.
- **Scan timing.**
  - The first capture occurs DWELL edges after the edge that enters SCAN.
  - Subsequent captures occur every DWELL cycles.
  - Each asserted cycle of hold delays the next capture by one cycle.
  - DWELL = 1: a capture on every edge; cur advances every cycle.
- **Capture value.** Data is sampled at the terminal edge, not at dwell start.
- **Combinational paths.** None from inputs to outputs; all outputs are registers.

## Test plan
All scenarios use CHANNELS=4, WIDTH=8, DWELL=4 unless stated.
- **Manual select.** mode=0, man_sel=2, in_data ch2=8'hA5 -> after 1 edge: out_data=8'hA5, out_chan=2, out_valid=1.
- **Manual out of range.** CHANNELS=6 build, man_sel=7 -> out_data=0, out_valid=0.
- **Full scan.** mode=1, chan_en=4'b1111, ch0..3 = 8'h10/11/12/13 -> out_valid pulses every 4 cycles; out_chan sequence 0,1,2,3,0; out_data 10,11,12,13,10. The first pulse is 4 edges after mode is sampled.
- **Masked scan.** chan_en=4'b1010 -> out_chan sequence 1,3,1,3.
  - Clear bit 3 during ch3's dwell -> no pulse at that terminal edge; the next pulse is ch1.
- **Halt and hold.**
  - chan_en=0 -> HALT, out_valid stays 0 for ≥20 cycles.
  - Then chan_en=4'b0100 -> a pulse with out_chan=2 occurs 4 edges later.
  - hold=1 for 3 cycles mid-dwell -> the next pulse occurs 3 cycles late.
- **Reset mid-scan.** Assert rst_n=0 asynchronously between edges at cnt=2 -> outputs are 0 immediately. After release with mode=1, the scan restarts from the lowest enabled channel and the first pulse occurs 4 edges after MANUAL→SCAN entry.

Source files
------------

// File: rtl/sensor_scan_mux.sv
// Registered N-to-1 sensor channel selector with manual selection and a
// round-robin scan mode (programmable dwell, per-channel enable mask, hold).
module sensor_scan_mux #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int DWELL    = 16,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          man_sel,
  input  logic                      hold,
  input  logic [CHANNELS-1:0]       chan_en,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid
);

  localparam int CNT_W = $clog2(DWELL) + 1;
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DWELL - 1);
  localparam logic [SEL_W:0]   CH_LIM   = (SEL_W + 1)'(CHANNELS);

  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    SCAN   = 2'd1,
    HALT   = 2'd2
  } state_t;

  state_t           state;
  logic [SEL_W-1:0] cur;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] man_data;
  logic [SEL_W-1:0] man_chan;
  logic             man_vld;

  function automatic logic [WIDTH-1:0] chan_data(
    input logic [SEL_W-1:0]          idx,
    input logic [CHANNELS*WIDTH-1:0] d
  );
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (idx == SEL_W'(i)) r = d[i*WIDTH +: WIDTH];
    end
    return r;
  endfunction

  function automatic logic [SEL_W-1:0] lowest_en(input logic [CHANNELS-1:0] en);
    logic [SEL_W-1:0] r;
    r = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (en[i]) r = SEL_W'(i);
    end
    return r;
  endfunction

  // Search cur+1, cur+2, ... wrapping, with cur itself as the last candidate.
  function automatic logic [SEL_W-1:0] next_en(
    input logic [SEL_W-1:0]    c,
    input logic [CHANNELS-1:0] en
  );
    logic [SEL_W-1:0] r;
    logic             found;
    r     = c;
    found = 1'b0;
    for (int k = 1; k <= CHANNELS; k++) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (!found && en[i] && (i == ((int'(c) + k) % CHANNELS))) begin
          r     = SEL_W'(i);
          found = 1'b1;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    man_data = '0;
    man_chan = '0;
    man_vld  = 1'b0;
    if ({1'b0, man_sel} < CH_LIM) begin
      man_data = chan_data(man_sel, in_data);
      man_chan = man_sel;
      man_vld  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= MANUAL;
      cur       <= '0;
      cnt       <= '0;
      out_data  <= '0;
      out_chan  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        MANUAL: begin
          if (mode) begin
            cnt       <= '0;
            cur       <= lowest_en(chan_en);
            out_valid <= 1'b0;
            state     <= (chan_en == '0) ? HALT : SCAN;
          end else begin
            out_data  <= man_data;
            out_chan  <= man_chan;
            out_valid <= man_vld;
          end
        end

        SCAN: begin
          if (!mode) begin
            state     <= MANUAL;
            cnt       <= '0;
            out_data  <= man_data;
            out_chan  <= man_chan;
            out_valid <= man_vld;
          end else if (chan_en == '0) begin
            state     <= HALT;
            cnt       <= '0;
            out_valid <= 1'b0;
          end else if (hold) begin
            out_valid <= 1'b0;
          end else if (cnt != CNT_TERM) begin
            cnt       <= cnt + 1'b1;
            out_valid <= 1'b0;
          end else begin
            // Terminal edge: capture only if the channel is still enabled.
            if (chan_en[cur]) begin
              out_data  <= chan_data(cur, in_data);
              out_chan  <= cur;
              out_valid <= 1'b1;
            end else begin
              out_valid <= 1'b0;
            end
            cnt <= '0;
            cur <= next_en(cur, chan_en);
          end
        end

        HALT: begin
          if (!mode) begin
            state     <= MANUAL;
            cnt       <= '0;
            out_data  <= man_data;
            out_chan  <= man_chan;
            out_valid <= man_vld;
          end else begin
            out_valid <= 1'b0;
            if (chan_en != '0) begin
              state <= SCAN;
              cnt   <= '0;
              cur   <= lowest_en(chan_en);
            end
          end
        end

        default: begin
          state     <= MANUAL;
          cnt       <= '0;
          cur       <= '0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
